// File: rtl/song_sequencer.sv
// Song ROM walker feeding note_player: fetches {note, duration} entries, issues new_note pulses.
// Build option LOOP_SONG_EN: end-of-song restarts the same song instead of parking in END.
module song_sequencer #(
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 6,
  parameter int SONG_BITS = 2,
  parameter int NOTE_BITS = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play,
  input  logic                           next_song,
  input  logic                           note_done,
  output logic [SONG_BITS+NOTE_BITS-1:0] rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]        rom_data,
  output logic [NOTE_W-1:0]              note_to_play,
  output logic [DUR_W-1:0]               duration_for_note,
  output logic                           new_note,
  output logic                           song_done,
  output logic [SONG_BITS-1:0]           current_song
);

  // state   | meaning
  // IDLE    | stopped; waits for play
  // FETCH   | ROM read of {current_song, note_index} in flight
  // CHECK   | rom_data valid; end marker, or issue note once play is high
  // PLAYING | note_player busy; waits for note_done
  // END     | song finished; waits for next_song
  typedef enum logic [2:0] {IDLE, FETCH, CHECK, PLAYING, END} state_t;

`ifdef LOOP_SONG_EN
  localparam state_t EOS_STATE = FETCH;
`else
  localparam state_t EOS_STATE = END;
`endif

  localparam logic [NOTE_BITS-1:0] LAST_IDX = '1;

  state_t                 state_q, state_d;
  logic [NOTE_BITS-1:0]   note_index, idx_d;
  logic [SONG_BITS-1:0]   song_d;
  logic [NOTE_W-1:0]      note_d;
  logic [DUR_W-1:0]       dur_d;
  logic                   new_note_d, song_done_d, end_of_song;
  logic [NOTE_W-1:0]      rom_note;
  logic [DUR_W-1:0]       rom_dur;

  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];
  assign rom_addr = {current_song, note_index};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      current_song      <= '0;
      note_index        <= '0;
      note_to_play      <= '0;
      duration_for_note <= '0;
      new_note          <= 1'b0;
      song_done         <= 1'b0;
    end else begin
      state_q           <= state_d;
      current_song      <= song_d;
      note_index        <= idx_d;
      note_to_play      <= note_d;
      duration_for_note <= dur_d;
      new_note          <= new_note_d;
      song_done         <= song_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    song_d      = current_song;
    idx_d       = note_index;
    note_d      = note_to_play;
    dur_d       = duration_for_note;
    new_note_d  = 1'b0;
    song_done_d = 1'b0;
    end_of_song = 1'b0;

    // next_song overrides everything, including a coincident note_done
    if (next_song) begin
      song_d  = current_song + SONG_BITS'(1);
      idx_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (play) state_d = FETCH;
        end
        FETCH: begin
          state_d = CHECK;
        end
        CHECK: begin
          if (rom_dur == '0) begin
            end_of_song = 1'b1;
          end else if (play) begin
            note_d     = rom_note;
            dur_d      = rom_dur;
            new_note_d = 1'b1;
            state_d    = PLAYING;
          end
        end
        PLAYING: begin
          if (note_done) begin
            if (note_index == LAST_IDX) begin
              end_of_song = 1'b1;
            end else begin
              idx_d   = note_index + NOTE_BITS'(1);
              state_d = FETCH;
            end
          end
        end
        END: begin
          state_d = END;
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (end_of_song) begin
        song_done_d = 1'b1;
        idx_d       = '0;
        state_d     = EOS_STATE;
      end
    end
  end

endmodule
